// File: rtl/blit_memstage.sv
// Blitter pipeline stage 3: memory side of RECT/COPY/TEXT pixels.
// One-word source cache skips re-reads of the same font/source word.
module blit_memstage #(
  parameter int CACHE_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p2_valid,
  input  logic        p2_is_mem,
  input  logic        p2_is_text,
  input  logic [25:0] p2_dst_address,
  input  logic [25:0] p2_src_address,
  input  logic [2:0]  p2_bit_index,
  output logic        p2_ready,
  input  logic        cmd_start,
  input  logic [7:0]  reg_color,
  input  logic [8:0]  reg_bgcolor,
  output logic        mem_request,
  output logic        mem_write,
  output logic [25:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT_DATA,
    WRITE
  } state_t;

  state_t      state;
  logic        is_text_q;
  logic [25:0] dst_q;
  logic [25:0] src_q;
  logic [2:0]  bidx_q;

  logic        cache_valid;
  logic [23:0] cache_tag;
  logic [31:0] cache_data;

  logic        hit;
  logic [7:0]  hit_byte;
  logic [7:0]  rd_byte;
  logic [8:0]  hit_rule;
  logic [8:0]  rd_rule;

  // Returns {do_write, byte}; non-text sources pass through unchanged.
  function automatic logic [8:0] text_rule(
    input logic [7:0] b,
    input logic       txt,
    input logic [2:0] idx,
    input logic [7:0] fg,
    input logic [8:0] bg
  );
    logic px;
    px = b[3'd7 - idx];
    if (!txt) return {1'b1, b};
    if (px) return {1'b1, fg};
    if (!bg[8]) return {1'b1, bg[7:0]};
    return 9'd0;
  endfunction

  assign p2_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Cache lookup for the incoming item and byte select of returning data.
  always_comb begin
    hit      = (CACHE_EN != 0) && cache_valid &&
               (cache_tag == p2_src_address[25:2]);
    hit_byte = cache_data[{p2_src_address[1:0], 3'b000} +: 8];
    rd_byte  = mem_rdata[{src_q[1:0], 3'b000} +: 8];
    hit_rule = text_rule(hit_byte, p2_is_text, p2_bit_index,
                         reg_color, reg_bgcolor);
    rd_rule  = text_rule(rd_byte, is_text_q, bidx_q,
                         reg_color, reg_bgcolor);
  end

  // Pixel FSM with registered bus outputs and cache maintenance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      is_text_q   <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      bidx_q      <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (p2_valid) begin
            is_text_q <= p2_is_text;
            dst_q     <= p2_dst_address;
            src_q     <= p2_src_address;
            bidx_q    <= p2_bit_index;
            if (!p2_is_mem) begin
              state       <= WRITE;
              mem_request <= 1'b1;
              mem_write   <= 1'b1;
              mem_address <= p2_dst_address;
              mem_wdata   <= {4{p2_src_address[7:0]}};
              mem_byte_en <= 4'b0001 << p2_dst_address[1:0];
            end else if (hit) begin
              if (hit_rule[8]) begin
                state       <= WRITE;
                mem_request <= 1'b1;
                mem_write   <= 1'b1;
                mem_address <= p2_dst_address;
                mem_wdata   <= {4{hit_rule[7:0]}};
                mem_byte_en <= 4'b0001 << p2_dst_address[1:0];
              end
            end else begin
              state       <= READ;
              mem_request <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= p2_src_address;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            if (mem_rvalid) begin
              cache_valid <= (CACHE_EN != 0);
              cache_tag   <= src_q[25:2];
              cache_data  <= mem_rdata;
              if (rd_rule[8]) begin
                state       <= WRITE;
                mem_write   <= 1'b1;
                mem_address <= dst_q;
                mem_wdata   <= {4{rd_rule[7:0]}};
                mem_byte_en <= 4'b0001 << dst_q[1:0];
              end else begin
                state       <= IDLE;
                mem_request <= 1'b0;
              end
            end else begin
              state       <= WAIT_DATA;
              mem_request <= 1'b0;
            end
          end
        end
        WAIT_DATA: begin
          if (mem_rvalid) begin
            cache_valid <= (CACHE_EN != 0);
            cache_tag   <= src_q[25:2];
            cache_data  <= mem_rdata;
            if (rd_rule[8]) begin
              state       <= WRITE;
              mem_request <= 1'b1;
              mem_write   <= 1'b1;
              mem_address <= dst_q;
              mem_wdata   <= {4{rd_rule[7:0]}};
              mem_byte_en <= 4'b0001 << dst_q[1:0];
            end else begin
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state       <= IDLE;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (cmd_start) cache_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blit_memstage.sv
// Bench for blit_memstage: vector table plus scoreboarded bus responder.
// Hand sequences cover RECT timing, stalls, bubbles, invalidation, reset.
module tb_blit_memstage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p2_valid = 1'b0;
  logic        p2_is_mem = 1'b0;
  logic        p2_is_text = 1'b0;
  logic [25:0] p2_dst_address = '0;
  logic [25:0] p2_src_address = '0;
  logic [2:0]  p2_bit_index = '0;
  logic        p2_ready;
  logic        cmd_start = 1'b0;
  logic [7:0]  reg_color = '0;
  logic [8:0]  reg_bgcolor = '0;
  logic        mem_request;
  logic        mem_write;
  logic [25:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  blit_memstage #(.CACHE_EN(1)) dut (
    .clock(clock), .reset(reset),
    .p2_valid(p2_valid), .p2_is_mem(p2_is_mem),
    .p2_is_text(p2_is_text),
    .p2_dst_address(p2_dst_address),
    .p2_src_address(p2_src_address),
    .p2_bit_index(p2_bit_index), .p2_ready(p2_ready),
    .cmd_start(cmd_start), .reg_color(reg_color),
    .reg_bgcolor(reg_bgcolor),
    .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    logic        v, m, t;
    logic [25:0] dst, src;
    logic [2:0]  bidx;
    logic [7:0]  color;
    logic [8:0]  bg;
    logic [31:0] rdata;
    logic        exp_rd, exp_wr;
    logic [7:0]  wbyte;
  } vec_t;

  txn_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int stall = 0;
  int stall_cnt = 0;
  int rv_delay = 1;
  int rd_wait = 0;
  logic [31:0] rd_word = '0;
  logic holding = 1'b0;
  logic [25:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_wr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input logic [25:0] a);
    txn_t e;
    e.wr = 1'b0; e.addr = a; e.wdata = '0; e.be = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [25:0] a, input logic [7:0] b);
    txn_t e;
    e.wr = 1'b1; e.addr = a; e.wdata = {4{b}};
    e.be = 4'b0001 << a[1:0];
    exp_q.push_back(e);
  endtask

  // Bus responder, stability monitor and scoreboard compare.
  always @(negedge clock) begin
    txn_t e;
    mem_rvalid = 1'b0;
    if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd_word;
      end
    end
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_request) begin
      if (!holding) begin
        holding = 1'b1;
        s_addr = mem_address; s_wdata = mem_wdata;
        s_be = mem_byte_en; s_wr = mem_write;
      end else begin
        chk("stall_addr", 32'(mem_address), 32'(s_addr));
        chk("stall_wdata", mem_wdata, s_wdata);
        chk("stall_be", 32'(mem_byte_en), 32'(s_be));
        chk("stall_wr", 32'(mem_write), 32'(s_wr));
      end
      if (stall_cnt < stall) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        holding = 1'b0;
        mem_ack = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn wr=%0d addr=%0h data=%0h",
                   mem_write, mem_address, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("txn_kind", 32'(mem_write), 32'(e.wr));
          chk("txn_addr", 32'(mem_address), 32'(e.addr));
          if (e.wr) begin
            chk("txn_wdata", mem_wdata, e.wdata);
            chk("txn_be", 32'(mem_byte_en), 32'(e.be));
          end
        end
        if (!mem_write) begin
          if (rv_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = rd_word;
          end else begin
            rd_wait = rv_delay;
          end
        end
      end
    end
  end

  task automatic send(input logic v, m, t, input logic [25:0] d, s,
                      input logic [2:0] b);
    int n = 0;
    while (!p2_ready && n < 100) begin @(negedge clock); n++; end
    if (!p2_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    p2_valid = v; p2_is_mem = m; p2_is_text = t;
    p2_dst_address = d; p2_src_address = s; p2_bit_index = b;
    @(negedge clock);
    p2_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clock); n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      failures++;
      $display("FAIL idle_wait busy=%0d pending=%0d want 0/0",
               busy, exp_q.size());
    end
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic v, m, t, input logic [25:0] dst, src,
    input logic [2:0] bidx, input logic [7:0] color,
    input logic [8:0] bg, input logic [31:0] rdata,
    input logic erd, ewr, input logic [7:0] wb);
    vec_t x;
    x.v = v; x.m = m; x.t = t; x.dst = dst; x.src = src;
    x.bidx = bidx; x.color = color; x.bg = bg; x.rdata = rdata;
    x.exp_rd = erd; x.exp_wr = ewr; x.wbyte = wb;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    // table: RECT, COPY miss/hit, bubble, TEXT transparent/opaque
    vecs.push_back(mk(1,0,0,26'h200,26'h0C3,0,0,0,0,0,1,8'hC3));
    vecs.push_back(mk(1,1,0,26'h3000,26'h2000,0,0,0,
                      32'h44332211,1,1,8'h11));
    vecs.push_back(mk(1,1,0,26'h3001,26'h2001,0,0,0,0,0,1,8'h22));
    vecs.push_back(mk(1,1,0,26'h3007,26'h2003,0,0,0,0,0,1,8'h44));
    vecs.push_back(mk(0,1,0,26'h3333,26'h9999,0,0,0,0,0,0,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,1,1,26'h5000 + 26'(i),26'h4000,3'(i),
                        8'h0F,9'h1A5,32'h80,(i == 0),(i == 0),8'h0F));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,1,1,26'h5100 + 26'(i),26'h4000,3'(i),
                        8'h0F,9'h033,0,0,1,(i == 0) ? 8'h0F : 8'h33));
    vecs.push_back(mk(1,1,1,26'h7003,26'h6002,3,8'h5A,9'h100,
                      32'h00F00000,1,1,8'h5A));
    vecs.push_back(mk(1,1,1,26'h7001,26'h6002,4,8'h5A,9'h100,
                      0,0,0,0));
    vecs.push_back(mk(1,1,1,26'h7002,26'h6002,4,8'h5A,9'h0EE,
                      0,0,1,8'hEE));

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(p2_ready), 1);
    chk("rst_req", 32'(mem_request), 0);
    chk("rst_wr", 32'(mem_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_byte_en), 0);
    reset = 1'b0;
    @(negedge clock);

    // RECT with ack one cycle after request: ready low 2 cycles
    stall = 1;
    exp_wr(26'h000105, 8'hA7);
    send(1, 0, 0, 26'h000105, 26'h0000A7, 0);
    chk("rect_ready_c1", 32'(p2_ready), 0);
    @(negedge clock);
    chk("rect_ready_c2", 32'(p2_ready), 0);
    @(negedge clock);
    chk("rect_ready_c3", 32'(p2_ready), 1);
    wait_idle();
    stall = 0;

    // vector table
    pulse_start();
    foreach (vecs[i]) begin
      reg_color = vecs[i].color;
      reg_bgcolor = vecs[i].bg;
      rd_word = vecs[i].rdata;
      if (vecs[i].exp_rd) exp_rd(vecs[i].src);
      if (vecs[i].exp_wr) exp_wr(vecs[i].dst, vecs[i].wbyte);
      send(vecs[i].v, vecs[i].m, vecs[i].t,
           vecs[i].dst, vecs[i].src, vecs[i].bidx);
      wait_idle();
    end

    // bus stall in READ and WRITE
    stall = 5;
    pulse_start();
    rd_word = 32'hDEADBEEF;
    exp_rd(26'h8000);
    exp_wr(26'h9001, 8'hEF);
    send(1, 1, 0, 26'h9001, 26'h8000, 0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_ready", 32'(p2_ready), 0);
      @(negedge clock);
    end
    wait_idle();
    stall = 0;

    // back-to-back bubbles
    p2_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p2_is_mem = 1'b1;
      p2_src_address = 26'(i);
      @(negedge clock);
      chk("bubble_ready", 32'(p2_ready), 1);
      chk("bubble_req", 32'(mem_request), 0);
    end

    // cmd_start between two same-word reads forces a re-read
    pulse_start();
    rd_word = 32'h000000AA;
    exp_rd(26'hA000);
    exp_wr(26'hB000, 8'hAA);
    send(1, 1, 0, 26'hB000, 26'hA000, 0);
    wait_idle();
    pulse_start();
    exp_rd(26'hA001);
    exp_wr(26'hB001, 8'h00);
    send(1, 1, 0, 26'hB001, 26'hA001, 0);
    wait_idle();

    // ack and rvalid in the same cycle
    rv_delay = 0;
    pulse_start();
    rd_word = 32'h00550000;
    exp_rd(26'hC002);
    exp_wr(26'hD000, 8'h55);
    send(1, 1, 0, 26'hD000, 26'hC002, 0);
    wait_idle();

    // reset while waiting for read data
    rv_delay = 4;
    rd_word = 32'h99999999;
    exp_rd(26'hE000);
    send(1, 1, 0, 26'hF000, 26'hE000, 0);
    begin
      int n = 0;
      while (!(busy && !mem_request) && n < 20) begin
        @(negedge clock); n++;
      end
    end
    chk("wait_data_reached", 32'(busy && !mem_request), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_req", 32'(mem_request), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(p2_ready), 1);
    chk("mid_rst_addr", 32'(mem_address), 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_be", 32'(mem_byte_en), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst_req", 32'(mem_request), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    chk("post_rst_pending", 32'(exp_q.size()), 0);
    rv_delay = 1;
    rd_word = 32'h12345678;
    exp_rd(26'hE000);
    exp_wr(26'hF000, 8'h78);
    send(1, 1, 0, 26'hF000, 26'hE000, 0);
    wait_idle();

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blit_memstage.md
Name: blit_memstage

Overview:
Third stage of the blitter pipeline. It consumes the per-pixel stream produced by the address generator (valid, is_mem, is_text, dest/src addresses, bit index) and drives the `p2_ready` backpressure back into it. For each valid pixel it performs the memory side of the operation:
- RECT: direct colour write.
- COPY: source byte read, then destination write.
- TEXT: font byte read, bit select, then colour write or skip.

A one-word source read cache avoids re-reading the same font/source word on consecutive pixels.

Parameters:
- CACHE_EN, 1, 1 = enable the single-word source read cache; 0 = every mem pixel issues a read.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p2_valid  in  1  pixel to draw (0 = bubble/clipped)
- p2_is_mem  in  1  source must be read from memory (COPY/TEXT)
- p2_is_text  in  1  source byte is a 1bpp font row
- p2_dst_address  in  26  destination byte address
- p2_src_address  in  26  source byte address; for RECT, bits [7:0] hold the colour
- p2_bit_index  in  3  pixel bit within font byte (TEXT only)
- p2_ready  out  1  stage can accept an item this cycle
- cmd_start  in  1  one-cycle pulse at start of each blit command; invalidates cache
- reg_color  in  8  text foreground colour
- reg_bgcolor  in  9  text background; bit 8 = 1 means transparent
- mem_request  out  1  bus request, held until mem_ack
- mem_write  out  1  1 = write, 0 = read
- mem_address  out  26  byte address
- mem_wdata  out  32  write data, byte replicated to all lanes
- mem_byte_en  out  4  one-hot lane = 1 << address[1:0]
- mem_ack  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word
- busy  out  1  item in flight (state != IDLE)

Behaviour:
- Reset values:
  - state IDLE.
  - `p2_ready`=1. It is a decode of state, low in every non-IDLE state.
  - `mem_request`, `mem_write`, `busy` = 0.
  - `mem_address`, `mem_wdata`, `mem_byte_en` = 0.
  - `cache_valid` = 0.
- States: IDLE, READ, WAIT_DATA, WRITE.
- Input accept happens in IDLE only (`p2_ready`=1). The item is latched on that clock edge.
  - `p2_valid`=0: item discarded, stay IDLE, no bus activity.
  - Valid and !`is_mem` (RECT): go to WRITE with data = `src_address[7:0]`. `mem_request` rises the cycle after accept (latency 1).
  - Valid and `is_mem`, cache hit (CACHE_EN, `cache_valid`, `cache_tag` == `src_address[25:2]`): byte selected from `cache_data`, then the text rule is applied (below). Goes to WRITE or IDLE with no read.
  - Valid and `is_mem`, miss: go to READ. `mem_request`=1, `mem_write`=0, `mem_address`=`src_address`.
- READ:
  - Hold all outputs stable until `mem_ack`.
  - Then go to WAIT_DATA and drop `mem_request`.
- WAIT_DATA:
  - On `mem_rvalid`, fill the cache (tag = `src_address[25:2]`, data = `mem_rdata`, valid = 1).
  - Select byte `rdata[8*src[1:0] +: 8]` and apply the text rule.
  - `mem_rvalid` and `mem_ack` arriving in the same cycle in READ is legal: treat as ack then data, go straight to the text rule.
- Text rule (`is_text`=1):
  - bit = byte[7 - `bit_index`] (bit_index 0 = leftmost pixel = MSB).
  - bit=1: write `reg_color`.
  - bit=0 and `reg_bgcolor[8]`=0: write `reg_bgcolor[7:0]`.
  - bit=0 and `reg_bgcolor[8]`=1: no write, return to IDLE.
  - Non-text COPY: write the selected byte unchanged.
- WRITE:
  - `mem_request`=1, `mem_write`=1, `mem_address`=`dst_address`.
  - `mem_wdata`={4{byte}}, `mem_byte_en`=1<<`dst[1:0]`.
  - Hold until `mem_ack`, then IDLE. `p2_ready` is high in the following cycle.
- Throughput: RECT is 1 pixel per 2 cycles minimum. A cache-hit pixel costs the same as RECT.
- `mem_ack` is ignored unless `mem_request`=1. `mem_rvalid` is ignored outside WAIT_DATA.
- `cmd_start` clears `cache_valid` the next cycle in any state. It takes priority over a same-cycle fill: the fill data is used for the current pixel but is not retained.
- Source writes are not snooped. Overlapping COPY relies on `cmd_start` invalidation plus the addrgen's scan order.
- Reset mid-operation: state goes to IDLE and `mem_request` drops on the reset edge. Any outstanding read data arriving later is discarded. The cache is invalidated.
- `busy`=1 whenever state != IDLE.

Test Plan:
- RECT: valid=1, is_mem=0, dst=0x000105, src=0x0000A7, ack next cycle -> one write: addr 0x000105, wdata 0xA7A7A7A7, byte_en 0010; `p2_ready` low for 2 cycles then high.
- COPY miss then hit: src 0x2000, then 0x2001, with rdata 0x44332211 -> exactly one read. Writes 0x11 then 0x22; the second pixel issues no read.
- TEXT, font byte 0x80, bgcolor 0x1xx (transparent), color 0x0F, bit_index 0..7 -> only bit_index 0 writes 0x0F; the other 7 produce no bus write. With bgcolor=0x033, all 8 write (0x0F, then 0x33 ×7).
- Bus stall: `mem_ack` held low 5 cycles in READ and WRITE -> request, address and data stable throughout; no second request; `p2_ready` stays 0.
- Bubble: `p2_valid`=0 items accepted back-to-back -> `p2_ready` stays 1, no `mem_request`. `cmd_start` between two same-word reads -> second read is issued.
- Reset asserted in WAIT_DATA, `mem_rvalid` arrives 2 cycles later -> outputs at reset values, no write issued, `cache_valid`=0.
